// File: rtl/cdbus_phy_pkg.sv
// Shared types and helpers for the cdbus line-side stage.
package cdbus_phy_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDrive = 2'd1,
      StHold  = 2'd2
   } tx_state_e;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/cdbus_phy_bus_if.sv
// Core-side and transceiver-side signals of the cdbus line stage.
interface cdbus_phy_bus_if;
   logic tx;
   logic tx_en;
   logic rx;
   logic bus_rx_raw;
   logic bus_tx;
   logic bus_de;
   logic collision;

   modport master (
      output tx, tx_en, bus_rx_raw,
      input  rx, bus_tx, bus_de, collision
   );

   modport slave (
      input  tx, tx_en, bus_rx_raw,
      output rx, bus_tx, bus_de, collision
   );
endinterface

// File: rtl/cdbus_rx_filter.sv
// Synchronises the asynchronous bus input and removes pulses shorter than FILT_LEN cycles.
module cdbus_rx_filter
   import cdbus_phy_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic bus_rx_raw_i,
   output logic rx_filt_o
);

   localparam int unsigned CntW = cnt_width(FILT_LEN);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   rx_filt_q, rx_filt_d;
   logic [CntW-1:0]        cnt_q, cnt_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      rx_filt_d = rx_filt_q;
      cnt_d     = '0;
      if (s != rx_filt_q) begin
         if (cnt_q == CntW'(FILT_LEN - 1)) begin
            rx_filt_d = s;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '1;
         rx_filt_q <= 1'b1;
         cnt_q     <= '0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], bus_rx_raw_i};
         rx_filt_q <= rx_filt_d;
         cnt_q     <= cnt_d;
      end
   end

   assign rx_filt_o = rx_filt_q;

endmodule

// File: rtl/cdbus_phy_if.sv
// cdbus line stage: rx deglitch, DE generation with post-transmit hold, collision flag.
module cdbus_phy_if
   import cdbus_phy_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 3,
   parameter int unsigned HOLD_CYC    = 8,
   parameter int unsigned COLL_DLY    = 6
) (
   input  logic            clk,
   input  logic            reset,
   cdbus_phy_bus_if.slave  phy
);

   localparam int unsigned HoldW     = cnt_width(HOLD_CYC);
   localparam int unsigned HoldLoadI = (HOLD_CYC == 0) ? 0 : HOLD_CYC - 1;

   tx_state_e           state_q, state_d;
   logic [HoldW-1:0]    hcnt_q, hcnt_d;
   logic                bus_tx_q, bus_tx_d;
   logic                bus_de_q, bus_de_d;
   logic [COLL_DLY-1:0] tx_pipe_q, drv_pipe_q;
   logic [COLL_DLY:0]   tx_tap, drv_tap;
   logic                rx_filt;
   logic                mism, mism_q, coll_q;

   cdbus_rx_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_rx_filter (
      .clk          (clk),
      .reset        (reset),
      .bus_rx_raw_i (phy.bus_rx_raw),
      .rx_filt_o    (rx_filt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         hcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
      end
   end

   // A re-asserted tx_en in HOLD wins over hold expiry, so DE never drops.
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      unique case (state_q)
         StIdle: begin
            if (phy.tx_en) state_d = StDrive;
         end
         StDrive: begin
            if (!phy.tx_en) begin
               if (HOLD_CYC == 0) begin
                  state_d = StIdle;
               end else begin
                  state_d = StHold;
                  hcnt_d  = HoldW'(HoldLoadI);
               end
            end
         end
         StHold: begin
            if (phy.tx_en) begin
               state_d = StDrive;
            end else if (hcnt_q == '0) begin
               state_d = StIdle;
            end else begin
               hcnt_d = hcnt_q - HoldW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus_de_d = (state_d != StIdle);
      bus_tx_d = (state_d == StDrive) ? phy.tx : 1'b1;
   end

   // Delay the driven bit so it lines up with its own echo through the filter.
   assign tx_tap  = {tx_pipe_q, bus_tx_q};
   assign drv_tap = {drv_pipe_q, (state_q == StDrive)};
   assign mism    = drv_pipe_q[COLL_DLY-1] & (tx_pipe_q[COLL_DLY-1] != rx_filt);

   always_ff @(posedge clk) begin
      if (reset) begin
         bus_tx_q   <= 1'b1;
         bus_de_q   <= 1'b0;
         tx_pipe_q  <= '1;
         drv_pipe_q <= '0;
         mism_q     <= 1'b0;
         coll_q     <= 1'b0;
      end else begin
         bus_tx_q   <= bus_tx_d;
         bus_de_q   <= bus_de_d;
         tx_pipe_q  <= tx_tap[COLL_DLY-1:0];
         drv_pipe_q <= drv_tap[COLL_DLY-1:0];
         mism_q     <= mism;
         coll_q     <= mism & ~mism_q;
      end
   end

   assign phy.rx        = phy.tx_en ? phy.tx : rx_filt;
   assign phy.bus_tx    = bus_tx_q;
   assign phy.bus_de    = bus_de_q;
   assign phy.collision = coll_q;

endmodule

// File: tb/tb_cdbus_phy_if.sv
// Scoreboard bench for cdbus_phy_if: cycle-indexed reference model feeds a queue, monitor compares.
module tb_cdbus_phy_if;

   localparam int SYNC = 2;
   localparam int FILT = 3;
   localparam int HOLD = 8;
   localparam int COLL = 6;
   localparam int N    = 4096;

   typedef struct {
      int n;
      bit de;
      bit btx;
      bit rx;
      bit coll;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cdbus_phy_bus_if phy ();

   cdbus_phy_if #(
      .SYNC_STAGES (SYNC),
      .FILT_LEN    (FILT),
      .HOLD_CYC    (HOLD),
      .COLL_DLY    (COLL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .phy   (phy)
   );

   // History of applied inputs and derived model values, indexed by clock edge number.
   bit   en_a[N], raw_a[N], s_a[N], filt_a[N], drv_a[N], btx_a[N], mism_a[N];
   int   lr = 0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   popped = 0;
   exp_t sbq[$];

   task automatic chk(input string nm, input int n, input logic act, input bit ex);
      total++;
      if (act !== ex) begin
         bad++;
         $display("FAIL %s edge=%0d got=%b want=%b", nm, n, act, ex);
      end
   endtask

   // Apply one cycle of stimulus; lp loops the expected bus_tx of the previous edge back as raw.
   task automatic step(input bit rst, input bit en, input bit txv, input bit lp, input bit rv);
      int   n;
      bit   raw, v, flip, de;
      exp_t e;
      n   = cyc + 1;
      raw = lp ? btx_a[n-1] : rv;
      reset          = rst;
      phy.tx_en      = en;
      phy.tx         = txv;
      phy.bus_rx_raw = raw;
      en_a[n]  = en;
      raw_a[n] = raw;
      if (rst) lr = n;
      s_a[n] = rst ? 1'b1 : ((n - SYNC + 1 > lr) ? raw_a[n-SYNC+1] : 1'b1);
      if (rst) begin
         filt_a[n] = 1'b1;
      end else begin
         v    = s_a[n-1];
         flip = 1'b0;
         if (n - FILT >= lr && v != filt_a[n-1]) begin
            flip = 1'b1;
            for (int k = 1; k <= FILT; k++) if (s_a[n-k] != v) flip = 1'b0;
         end
         filt_a[n] = flip ? v : filt_a[n-1];
      end
      // DE is high while tx_en was seen within the last HOLD edges since reset.
      de = 1'b0;
      if (!rst) begin
         for (int j = ((n - HOLD > lr + 1) ? n - HOLD : lr + 1); j <= n; j++) begin
            if (en_a[j]) de = 1'b1;
         end
      end
      drv_a[n]  = !rst && en;
      btx_a[n]  = drv_a[n] ? txv : 1'b1;
      mism_a[n] = !rst && (n - COLL >= lr) && drv_a[n-COLL] && (btx_a[n-COLL] != filt_a[n]);
      e.n    = n;
      e.de   = de;
      e.btx  = btx_a[n];
      e.rx   = en ? txv : filt_a[n];
      e.coll = 1'b0;
      if (!rst) e.coll = mism_a[n-1] && !mism_a[n-2];
      sbq.push_back(e);
      @(posedge clk);
      #2;
      cyc = n;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            popped++;
            chk("bus_de", e.n, phy.bus_de, e.de);
            chk("bus_tx", e.n, phy.bus_tx, e.btx);
            chk("rx", e.n, phy.rx, e.rx);
            chk("collision", e.n, phy.collision, e.coll);
         end
      end
   end

   initial begin : stim
      bit en, txv, lp, rv, rst;
      int fcnt;
      // Reset, then glitch and real edges on the raw input.
      repeat (3) step(1, 0, 0, 0, 1);
      repeat (4) step(0, 0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0, 0);
      repeat (10) step(0, 0, 0, 0, 1);
      repeat (8) step(0, 0, 0, 0, 0);
      repeat (12) step(0, 0, 0, 0, 1);
      // Looped-back frame with hold, then a frame re-entered from HOLD.
      for (int i = 0; i < 10; i++) step(0, 1, i[0], 1, 0);
      repeat (14) step(0, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) step(0, 1, $urandom_range(0, 1), 1, 0);
      repeat (3) step(0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 1, $urandom_range(0, 1), 1, 0);
      repeat (14) step(0, 0, 0, 1, 0);
      // Forced dominant echo while transmitting recessive.
      repeat (4) step(0, 1, 1, 1, 0);
      repeat (6) step(0, 1, 1, 0, 0);
      repeat (10) step(0, 1, 1, 1, 0);
      repeat (14) step(0, 0, 0, 1, 0);
      // Reset mid-DRIVE, then a clean frame.
      repeat (5) step(0, 1, 0, 1, 0);
      step(1, 1, 0, 1, 0);
      repeat (3) step(0, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) step(0, 1, $urandom_range(0, 1), 1, 0);
      repeat (14) step(0, 0, 0, 1, 0);
      // Random traffic with injected raw-line disturbances.
      en   = 1'b0;
      fcnt = 0;
      rv   = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) en = !en;
         txv = 1'($urandom_range(0, 1));
         if (fcnt == 0 && $urandom_range(0, 29) == 0) begin
            fcnt = $urandom_range(1, 6);
            rv   = 1'($urandom_range(0, 1));
         end
         lp = (fcnt == 0);
         if (fcnt > 0) fcnt--;
         rst = ($urandom_range(0, 299) == 0);
         step(rst, en, txv, lp, rv);
      end
      repeat (14) step(0, 0, 0, 1, 0);
      @(posedge clk);
      #3;
      total++;
      if (popped != cyc || sbq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain popped=%0d want=%0d left=%0d", popped, cyc, sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
